full_mat_unload: RTL and testbench
==================================

// Module: full_mat_unload
// PURPOSE
//  Result-side unloader for the 6x6 matrix/parallel multiplier. On a capture strobe it
//  snapshots the full N x N result array (27-bit words) and streams it out one word per
//  accepted beat over a valid/ready interface, row-major, toward the bus/register side.
//  It decouples the multiplier, which may start the next operation, from a slow reader.
// PARAMETERS
//  N   6   matrix dimension; N*N words per frame (N >= 2)
//  W   27  word width, equal to the multiplier result width
//  IW  3   row/col index width, $clog2(N)
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous reset, active-high
//  cap        in   1      capture strobe: snapshot result_in, start a frame
//  result_in  in   N*N*W  flat result array; word [r][c] at bits ((r*N+c)*W) +: W
//  out_valid  out  1      out_data/out_row/out_col/out_last hold a valid beat
//  out_ready  in   1      consumer accepts the beat this cycle when out_valid=1
//  out_data   out  W      word [out_row][out_col] of the snapshot
//  out_row    out  IW     row index of the current beat
//  out_col    out  IW     column index of the current beat
//  out_last   out  1      current beat is [N-1][N-1]
//  busy       out  1      frame in progress (state STREAM)
//  overrun    out  1      sticky: cap arrived while busy and was not accepted
//  clr_ovr    in   1      synchronous clear of overrun
// BEHAVIOUR
//  Reset (async): state IDLE; snapshot, out_data, out_row, out_col = 0;
//   out_valid, out_last, busy, overrun = 0.
//  States:
//   IDLE   - out_valid=0. cap=1 -> load snapshot, row=col=0, go to STREAM.
//   STREAM - out_valid=1. A beat fires when out_valid & out_ready.
//  Latency: cap at edge k -> out_valid=1 with word [0][0] from edge k+1.
//  Beat advance: col++; when col=N-1, col wraps to 0 and row++.
//   The beat at row=col=N-1 has out_last=1. Firing it returns to IDLE.
//  Hold: while out_valid & !out_ready, all out_* outputs are held stable.
//  Snapshot: captured only on an accepted cap. result_in changes mid-frame do not
//   affect the streamed data.
//  cap in STREAM without a last beat firing: ignored; overrun<=1, busy stays 1.
//  cap on the same cycle the last beat fires: accepted back-to-back. New snapshot
//   loads, row=col=0, state stays STREAM, no idle cycle, overrun unchanged.
//  overrun: cleared by rst or by clr_ovr. If clr_ovr and a new overrun occur in the
//   same cycle, overrun stays 1 (set wins).
//  out_data is a registered copy of snapshot[row][col]; no arithmetic or sign change.
//  Reset mid-frame: frame aborted immediately; all outputs at reset values.
//  Throughput: with out_ready held 1, N*N consecutive beats, one per cycle.
// TESTING
//  1 Reset: assert rst mid-frame -> out_valid=0, busy=0, overrun=0, out_data=0
//    asynchronously, before the next edge.
//  2 Frame: word[r][c]=r*6+c+1, cap=1 one cycle, out_ready=1 -> 36 beats on
//    consecutive cycles with data 1..36; out_last only on data=36; busy=0 after.
//  3 Backpressure: out_ready toggled 1,0,0,1,... -> every beat is held while ready=0;
//    no beat is dropped or duplicated; data sequence is still 1..36.
//  4 Snapshot isolation: after cap, drive result_in to all 27'h7FFFFFF -> the
//    streamed frame still equals the captured values 1..36.
//  5 Overrun: cap at beat 10 -> overrun=1, stream continues unchanged; clr_ovr=1
//    -> overrun=0; a cap the same cycle as clr_ovr -> overrun stays 1.
//  6 Back-to-back: cap in the same cycle as the out_last beat fires, new frame
//    word[r][c]=100+r*6+c -> next cycle shows out_row=0, out_col=0, data=100,
//    out_valid=1, and overrun stays 0.

Source files
------------

// File: rtl/full_mat_unload.sv
// Result-side unloader: snapshots an N x N result array on a capture strobe and streams it
// row-major over valid/ready, so the multiplier can move on while a slow reader drains it.
module full_mat_unload #(
    parameter int unsigned N  = 6,
    parameter int unsigned W  = 27,
    parameter int unsigned IW = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cap,
    input  logic [N*N*W-1:0]  i_result_in,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [W-1:0]      o_out_data,
    output logic [IW-1:0]     o_out_row,
    output logic [IW-1:0]     o_out_col,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_overrun,
    input  logic              i_clr_ovr
);

    localparam int unsigned NN = N * N;
    localparam int unsigned XW = $clog2(NN);

    typedef enum logic {StIdle, StStream} state_e;

    state_e          r_state, w_state_nxt;
    logic [W-1:0]    r_snap [NN];
    logic [W-1:0]    r_data, w_data_nxt;
    logic [IW-1:0]   r_row, w_row_nxt;
    logic [IW-1:0]   r_col, w_col_nxt;
    logic            r_last, w_last_nxt;
    logic            r_ovr, w_ovr_nxt;
    logic            w_fire, w_last_fire, w_accept;
    logic [XW-1:0]   w_nidx;

    assign w_fire      = (r_state == StStream) & i_out_ready;
    assign w_last_fire = w_fire & r_last;
    // A cap is taken when idle or exactly as the final beat leaves (back-to-back frames).
    assign w_accept    = i_cap & ((r_state == StIdle) | w_last_fire);

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_ovr_nxt   = r_ovr;
        w_nidx      = '0;

        if (w_accept) begin
            w_state_nxt = StStream;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_data_nxt  = i_result_in[W-1:0];
            w_last_nxt  = 1'b0;
        end else if (w_last_fire) begin
            w_state_nxt = StIdle;
            w_last_nxt  = 1'b0;
        end else if (w_fire) begin
            if (r_col == IW'(N - 1)) begin
                w_col_nxt = '0;
                w_row_nxt = r_row + IW'(1);
            end else begin
                w_col_nxt = r_col + IW'(1);
            end
            w_nidx     = XW'(w_row_nxt) * XW'(N) + XW'(w_col_nxt);
            w_data_nxt = r_snap[w_nidx];
            w_last_nxt = (w_nidx == XW'(NN - 1));
        end

        // Set has priority over the clear.
        if (i_cap & (r_state == StStream) & ~w_last_fire) begin
            w_ovr_nxt = 1'b1;
        end else if (i_clr_ovr) begin
            w_ovr_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_row   <= '0;
            r_col   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NN; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NN; i++) begin
                r_snap[i] <= i_result_in[i*W +: W];
            end
        end
    end

    assign o_out_valid = (r_state == StStream);
    assign o_busy      = (r_state == StStream);
    assign o_out_data  = r_data;
    assign o_out_row   = r_row;
    assign o_out_col   = r_col;
    assign o_out_last  = r_last;
    assign o_overrun   = r_ovr;

endmodule

// File: tb/tb_full_mat_unload.sv
// Directed bench for full_mat_unload: frames, backpressure, snapshot isolation, overrun,
// back-to-back capture and asynchronous reset.
module tb_full_mat_unload;

    localparam int unsigned N  = 6;
    localparam int unsigned W  = 27;
    localparam int unsigned IW = 3;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_cap = 1'b0;
    logic [N*N*W-1:0]  i_result_in = '0;
    logic              i_out_ready = 1'b0;
    logic              i_clr_ovr = 1'b0;
    logic              o_out_valid;
    logic [W-1:0]      o_out_data;
    logic [IW-1:0]     o_out_row;
    logic [IW-1:0]     o_out_col;
    logic              o_out_last;
    logic              o_busy;
    logic              o_overrun;

    int n_chk  = 0;
    int n_fail = 0;

    full_mat_unload #(.N(N), .W(W), .IW(IW)) u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cap       (i_cap),
        .i_result_in (i_result_in),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_row   (o_out_row),
        .o_out_col   (o_out_col),
        .o_out_last  (o_out_last),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun),
        .i_clr_ovr   (i_clr_ovr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_frame(input int base);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                i_result_in[(r*6+c)*27 +: 27] = 27'(base + r*6 + c);
            end
        end
    endtask

    // Pulse cap for one cycle; returns at the negedge after the capturing edge.
    task automatic capture();
        i_cap = 1'b1;
        @(negedge i_clk);
        i_cap = 1'b0;
    endtask

    // Drains one frame starting at beat 0; optionally raises cap on beat cap_at and loads a
    // new frame base alongside it.
    task automatic run_frame(input int base, input bit bp, input int cap_at, input int new_base);
        int  n   = 0;
        int  cyc = 0;
        bit  rdy;
        while (n < 36 && cyc < 400) begin
            rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            i_out_ready = rdy;
            i_cap = (n == cap_at);
            if (n == cap_at && new_base >= 0) set_frame(new_base);
            chk("valid", 64'(o_out_valid), 64'(1));
            chk("data", 64'(o_out_data), 64'(base + n));
            chk("row", 64'(o_out_row), 64'(n / 6));
            chk("col", 64'(o_out_col), 64'(n % 6));
            chk("last", 64'(o_out_last), 64'(n == 35));
            if (rdy) n++;
            cyc++;
            @(negedge i_clk);
        end
        i_cap = 1'b0;
        if (n != 36) chk("frame_timeout", 64'(n), 64'(36));
        if (cap_at != 35) begin
            chk("idle_valid", 64'(o_out_valid), 64'(0));
            chk("idle_busy", 64'(o_busy), 64'(0));
        end
    endtask

    initial begin
        #12;
        chk("rst_valid", 64'(o_out_valid), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_data", 64'(o_out_data), 64'(0));
        chk("rst_last", 64'(o_out_last), 64'(0));
        chk("rst_ovr", 64'(o_overrun), 64'(0));
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Plain frame, no backpressure.
        set_frame(1);
        capture();
        run_frame(1, 1'b0, -1, -1);

        // Backpressure pattern 1,0,0,1.
        capture();
        run_frame(1, 1'b1, -1, -1);

        // Snapshot isolation.
        capture();
        i_result_in = '1;
        run_frame(1, 1'b0, -1, -1);

        // Overrun: cap at beat 10, stream unaffected.
        set_frame(1);
        capture();
        run_frame(1, 1'b0, 10, -1);
        chk("ovr_set", 64'(o_overrun), 64'(1));
        i_clr_ovr = 1'b1;
        @(negedge i_clk);
        i_clr_ovr = 1'b0;
        chk("ovr_clr", 64'(o_overrun), 64'(0));

        // cap together with clr_ovr while streaming: set wins.
        capture();
        i_out_ready = 1'b0;
        i_cap = 1'b1;
        i_clr_ovr = 1'b1;
        @(negedge i_clk);
        i_cap = 1'b0;
        i_clr_ovr = 1'b0;
        chk("ovr_setwins", 64'(o_overrun), 64'(1));
        chk("ovr_busy", 64'(o_busy), 64'(1));
        chk("ovr_hold_data", 64'(o_out_data), 64'(1));
        i_clr_ovr = 1'b1;
        @(negedge i_clk);
        i_clr_ovr = 1'b0;
        chk("ovr_clr2", 64'(o_overrun), 64'(0));
        run_frame(1, 1'b0, -1, -1);

        // Back-to-back capture on the last beat.
        capture();
        run_frame(1, 1'b0, 35, 100);
        chk("b2b_valid", 64'(o_out_valid), 64'(1));
        chk("b2b_row", 64'(o_out_row), 64'(0));
        chk("b2b_col", 64'(o_out_col), 64'(0));
        chk("b2b_data", 64'(o_out_data), 64'(100));
        chk("b2b_ovr", 64'(o_overrun), 64'(0));
        run_frame(100, 1'b0, -1, -1);

        // Asynchronous reset mid-frame with overrun set.
        set_frame(1);
        capture();
        i_out_ready = 1'b1;
        i_cap = 1'b1;
        @(negedge i_clk);
        i_cap = 1'b0;
        @(negedge i_clk);
        chk("pre_rst_ovr", 64'(o_overrun), 64'(1));
        chk("pre_rst_data", 64'(o_out_data), 64'(3));
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_valid", 64'(o_out_valid), 64'(0));
        chk("arst_busy", 64'(o_busy), 64'(0));
        chk("arst_ovr", 64'(o_overrun), 64'(0));
        chk("arst_data", 64'(o_out_data), 64'(0));
        chk("arst_row", 64'(o_out_row), 64'(0));
        chk("arst_col", 64'(o_out_col), 64'(0));
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_valid", 64'(o_out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
